// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the multi-core Nios II JTAG debug command router.
// Holds the default configuration, the channel-width helper, the
// take_action encodings and the command record layout for that default
// configuration.
package nios_dbg_pkg;

  // Channel field width: at least one bit, even for a single-core system.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NUM_CH_DEF  = 2;
  localparam int IR_W_DEF    = 2;
  localparam int DATA_W_DEF  = 38;
  localparam int DEPTH_DEF   = 4;
  localparam int ACT_BIT_DEF = 34;
  localparam int CH_W_DEF    = ch_w(NUM_CH_DEF);

  // Value of jdo[ACT_BIT] meaning take_action / take_no_action.
  localparam logic ACT    = 1'b1;
  localparam logic NO_ACT = 1'b0;

  typedef struct packed {
    logic [CH_W_DEF-1:0]   chan;
    logic [IR_W_DEF-1:0]   ir;
    logic [DATA_W_DEF-1:0] jdo;
  } cmd_t;

endpackage

// File: rtl/nios_dbg_cmd_router_if.sv
// Per-channel command handshake between the router and the CPU debug ports.
//   cmd_valid  one-hot, head command is for channel i
//   cmd_ready  channel i accepts the head
//   cmd_ir     head instruction
//   cmd_jdo    head payload
//   cmd_action head take_action bit
// master: router side; slave: CPU debug port side.
interface nios_dbg_cmd_router_if #(
  parameter int NUM_CH = 2,
  parameter int IR_W   = 2,
  parameter int DATA_W = 38
) ();
  logic [NUM_CH-1:0] cmd_valid;
  logic [NUM_CH-1:0] cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_jdo;
  logic              cmd_action;

  modport master (
    output cmd_valid, cmd_ir, cmd_jdo, cmd_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_jdo, cmd_action,
    output cmd_ready
  );
endinterface

// File: rtl/nios_dbg_toggle_sync.sv
// Turns a toggle arriving from the TCK domain into a one-cycle event pulse
// in the clk domain: two synchroniser flops, a history flop, and a
// registered XOR of synchroniser output against history.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   tgl         asynchronous toggle input
//   evt         one-cycle pulse, high in cycle k+2 for a change sampled at edge k
module nios_dbg_toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic evt
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
      evt     <= 1'b0;
    end else begin
      // stage 0/1: metastability filter
      sync_p0 <= tgl;
      sync_p1 <= sync_p0;
      // stage 2: edge detect against the previous synchronised level
      hist_p2 <= sync_p1;
      evt     <= sync_p1 ^ hist_p2;
    end
  end

endmodule

// File: rtl/nios_dbg_cmd_router.sv
// Clock-domain command engine for the multi-core JTAG debug slave.
// Update-IR events latch the instruction; Update-DR events form a command
// {chan, ir, jdo} that is queued in a small FIFO and presented to the CPU
// debug port selected by chan through a valid/ready handshake.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   uir_tgl, udr_tgl    Update-IR / Update-DR toggles from the TCK domain
//   ir_in               instruction register contents
//   sr                  {chan, payload} data shift register contents
//   cmd                 handshake interface (master side)
//   fifo_level          occupied FIFO entries
//   overflow, bad_chan  sticky drop causes
//   drop_cnt            saturating dropped-command count
//   clr_status          pulse clearing overflow, bad_chan and drop_cnt
module nios_dbg_cmd_router
  import nios_dbg_pkg::*;
#(
  parameter  int NUM_CH  = NUM_CH_DEF,
  parameter  int IR_W    = IR_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int ACT_BIT = ACT_BIT_DEF,
  localparam int CH_W    = ch_w(NUM_CH),
  localparam int SR_W    = DATA_W + CH_W,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uir_tgl,
  input  logic                  udr_tgl,
  input  logic [IR_W-1:0]       ir_in,
  input  logic [SR_W-1:0]       sr,
  nios_dbg_cmd_router_if.master cmd,
  output logic [LW-1:0]         fifo_level,
  output logic                  overflow,
  output logic                  bad_chan,
  output logic [7:0]            drop_cnt,
  input  logic                  clr_status
);

  typedef struct packed {
    logic [CH_W-1:0]   chan;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] jdo;
  } entry_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic            uir_evt;
  logic            udr_evt;
  logic [IR_W-1:0] ir_lat;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  entry_t          head;
  entry_t          new_cmd;
  logic [CH_W-1:0] chan_in;
  logic            chan_bad;
  logic            full;
  logic            empty;
  logic            pop;
  logic            wr_en;
  logic            drop;

  nios_dbg_toggle_sync u_uir_sync (.clk(clk), .reset(reset), .tgl(uir_tgl), .evt(uir_evt));
  nios_dbg_toggle_sync u_udr_sync (.clk(clk), .reset(reset), .tgl(udr_tgl), .evt(udr_evt));

  // A same-cycle Update-DR still sees the old ir_lat because this update
  // lands on the same edge as the FIFO write.
  always_ff @(posedge clk) begin
    if (reset)        ir_lat <= '0;
    else if (uir_evt) ir_lat <= ir_in;
  end

  assign chan_in  = sr[SR_W-1 -: CH_W];
  assign chan_bad = (int'(chan_in) >= NUM_CH);
  assign new_cmd  = '{chan: chan_in, ir: ir_lat, jdo: sr[DATA_W-1:0]};

  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign head  = mem[rd_ptr];
  assign pop   = |(cmd.cmd_valid & cmd.cmd_ready);

  // Fullness is judged before any same-edge pop, so a write colliding with a
  // pop on a full FIFO is dropped.
  assign wr_en = udr_evt && !chan_bad && !full;
  assign drop  = udr_evt && (chan_bad || full);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= new_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;

  always_comb begin
    cmd.cmd_valid = '0;
    if (!empty) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (head.chan == CH_W'(i)) cmd.cmd_valid[i] = 1'b1;
      end
    end
  end

  assign cmd.cmd_ir     = empty ? '0 : head.ir;
  assign cmd.cmd_jdo    = empty ? '0 : head.jdo;
  assign cmd.cmd_action = !empty && (head.jdo[ACT_BIT] == ACT);

  // Clear takes priority over a coincident drop.
  always_ff @(posedge clk) begin
    if (reset || clr_status) begin
      overflow <= 1'b0;
      bad_chan <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      if (chan_bad) bad_chan <= 1'b1;
      else          overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_nios_dbg_cmd_router.sv
module tb_nios_dbg_cmd_router;

  localparam int NUM_CH  = 2;
  localparam int IR_W    = 2;
  localparam int DATA_W  = 38;
  localparam int DEPTH   = 4;
  localparam int ACT_BIT = 34;
  localparam int CH_W    = 1;
  localparam int SR_W    = DATA_W + CH_W;
  localparam int LW      = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              uir_tgl;
  logic              udr_tgl;
  logic [IR_W-1:0]   ir_in;
  logic [SR_W-1:0]   sr;
  logic [LW-1:0]     fifo_level;
  logic              overflow;
  logic              bad_chan;
  logic [7:0]        drop_cnt;
  logic              clr_status;

  nios_dbg_cmd_router_if #(.NUM_CH(NUM_CH), .IR_W(IR_W), .DATA_W(DATA_W)) cmd_if ();

  nios_dbg_cmd_router #(
    .NUM_CH(NUM_CH), .IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ACT_BIT(ACT_BIT)
  ) dut (
    .clk(clk), .reset(reset), .uir_tgl(uir_tgl), .udr_tgl(udr_tgl),
    .ir_in(ir_in), .sr(sr), .cmd(cmd_if), .fifo_level(fifo_level),
    .overflow(overflow), .bad_chan(bad_chan), .drop_cnt(drop_cnt),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of commands, a latched IR, status counters and a
  // list of pending JTAG updates that take effect 4 edges after being driven.
  typedef struct {
    logic [CH_W-1:0]   chan;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] jdo;
  } ent_t;

  typedef struct {
    int              due;
    bit              is_udr;
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } ev_t;

  ent_t            mq[$];
  ev_t             evq[$];
  logic [IR_W-1:0] m_ir;
  bit              m_ovf;
  bit              m_bad;
  int              m_drop;
  int              cyc = 0;

  always @(posedge clk) begin
    ev_t             keep[$];
    bit              u_hit;
    bit              i_hit;
    bit              do_pop;
    bit              dropped;
    logic [SR_W-1:0] u_sr;
    logic [IR_W-1:0] i_ir;
    ent_t            e;
    cyc++;
    if (reset) begin
      mq.delete();
      evq.delete();
      m_ir = '0; m_ovf = 0; m_bad = 0; m_drop = 0;
    end else begin
      u_hit = 0; i_hit = 0; u_sr = '0; i_ir = '0; dropped = 0;
      keep.delete();
      foreach (evq[i]) begin
        if (evq[i].due == cyc) begin
          if (evq[i].is_udr) begin u_hit = 1; u_sr = evq[i].sr; end
          else begin i_hit = 1; i_ir = evq[i].ir; end
        end else keep.push_back(evq[i]);
      end
      evq = keep;
      do_pop = (mq.size() != 0) && cmd_if.cmd_ready[mq[0].chan];
      if (u_hit) begin
        e.chan = u_sr[SR_W-1 -: CH_W];
        e.ir   = m_ir;
        e.jdo  = u_sr[DATA_W-1:0];
        if (int'(e.chan) >= NUM_CH) begin m_bad = 1; dropped = 1; end
        else if (mq.size() == DEPTH) begin m_ovf = 1; dropped = 1; end
        else mq.push_back(e);
      end
      if (do_pop) void'(mq.pop_front());
      if (clr_status) begin
        m_ovf = 0; m_bad = 0; m_drop = 0;
      end else if (dropped && m_drop < 255) m_drop++;
      if (i_hit) m_ir = i_ir;
    end
  end

  always @(negedge clk) begin
    logic [NUM_CH-1:0] ev;
    if (chk_en) begin
      ev = (mq.size() != 0) ? (NUM_CH'(1) << mq[0].chan) : '0;
      chk("m_valid",  64'(cmd_if.cmd_valid),  64'(ev));
      chk("m_ir",     64'(cmd_if.cmd_ir),     (mq.size() != 0) ? 64'(mq[0].ir) : 64'd0);
      chk("m_jdo",    64'(cmd_if.cmd_jdo),    (mq.size() != 0) ? 64'(mq[0].jdo) : 64'd0);
      chk("m_action", 64'(cmd_if.cmd_action), (mq.size() != 0) ? 64'(mq[0].jdo[ACT_BIT]) : 64'd0);
      chk("m_level",  64'(fifo_level),        64'(mq.size()));
      chk("m_ovf",    64'(overflow),          64'(m_ovf));
      chk("m_bad",    64'(bad_chan),          64'(m_bad));
      chk("m_drop",   64'(drop_cnt),          64'(m_drop));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_uir(input logic [IR_W-1:0] v);
    ev_t e;
    ir_in   = v;
    uir_tgl = ~uir_tgl;
    e.due = cyc + 4; e.is_udr = 0; e.ir = v; e.sr = '0;
    evq.push_back(e);
  endtask

  task automatic send_udr(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] jdo);
    ev_t e;
    sr      = {ch, jdo};
    udr_tgl = ~udr_tgl;
    e.due = cyc + 4; e.is_udr = 1; e.ir = '0; e.sr = {ch, jdo};
    evq.push_back(e);
  endtask

  // The TCK side is reset alongside, so the toggle lines return to 0.
  task automatic do_reset();
    reset = 1'b1;
    uir_tgl = 1'b0;
    udr_tgl = 1'b0;
    cmd_if.cmd_ready = '0;
    clr_status = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_jdo();
    return DATA_W'({$urandom, $urandom});
  endfunction

  logic [DATA_W-1:0] p [5];

  initial begin
    reset = 1'b1; uir_tgl = 0; udr_tgl = 0; ir_in = '0; sr = '0;
    clr_status = 0; cmd_if.cmd_ready = '0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_jdo",   64'(cmd_if.cmd_jdo), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);

    // first command: channel 1, take_action
    send_uir(2'b01); tick(4);
    send_udr(1'b1, 38'h04_0000_0000); tick(3);
    chk("t1_early_valid", 64'(cmd_if.cmd_valid), 64'd0);
    tick(1);
    chk("t1_valid",  64'(cmd_if.cmd_valid), 64'b10);
    chk("t1_ir",     64'(cmd_if.cmd_ir), 64'd1);
    chk("t1_action", 64'(cmd_if.cmd_action), 64'd1);
    chk("t1_level",  64'(fifo_level), 64'd1);
    cmd_if.cmd_ready = 2'b10; tick(1); cmd_if.cmd_ready = '0;
    chk("t1_popped", 64'(fifo_level), 64'd0);

    // five writes into a 4-deep FIFO, then drain in order at 1/clk
    for (int k = 0; k < 5; k++) begin
      p[k] = rnd_jdo();
      send_udr(1'b0, p[k]); tick(4);
    end
    chk("t2_level", 64'(fifo_level), 64'd4);
    chk("t2_ovf",   64'(overflow), 64'd1);
    chk("t2_drop",  64'(drop_cnt), 64'd1);
    cmd_if.cmd_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", 64'(cmd_if.cmd_jdo), 64'(p[k]));
      tick(1);
    end
    cmd_if.cmd_ready = '0;
    chk("t2_empty", 64'(fifo_level), 64'd0);
    chk("t2_valid", 64'(cmd_if.cmd_valid), 64'd0);

    clr_status = 1; tick(1); clr_status = 0;
    chk("clr_ovf",  64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // ready on the wrong channel never pops
    send_udr(1'b1, rnd_jdo()); tick(4);
    cmd_if.cmd_ready = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("t3_hold_valid", 64'(cmd_if.cmd_valid), 64'b10);
      chk("t3_hold_level", 64'(fifo_level), 64'd1);
    end
    cmd_if.cmd_ready = 2'b10; tick(1); cmd_if.cmd_ready = '0;
    chk("t3_pop", 64'(fifo_level), 64'd0);

    // full FIFO: write collides with a pop
    for (int k = 0; k < 4; k++) begin send_udr(1'b0, rnd_jdo()); tick(4); end
    send_udr(1'b0, rnd_jdo()); tick(3);
    cmd_if.cmd_ready = 2'b01; tick(1); cmd_if.cmd_ready = '0;
    chk("t4_level", 64'(fifo_level), 64'd3);
    chk("t4_ovf",   64'(overflow), 64'd1);
    chk("t4_drop",  64'(drop_cnt), 64'd1);
    send_udr(1'b0, rnd_jdo()); tick(4);
    chk("t4_refill", 64'(fifo_level), 64'd4);
    // clear coinciding with a drop
    send_udr(1'b0, rnd_jdo()); tick(3);
    clr_status = 1; tick(1); clr_status = 0;
    chk("t4_clr_drop", 64'(drop_cnt), 64'd0);
    chk("t4_clr_ovf",  64'(overflow), 64'd0);
    chk("t4_clr_lvl",  64'(fifo_level), 64'd4);
    // saturation
    for (int k = 0; k < 260; k++) begin send_udr(1'b0, rnd_jdo()); tick(4); end
    chk("t4_sat", 64'(drop_cnt), 64'd255);
    cmd_if.cmd_ready = 2'b01; tick(4); cmd_if.cmd_ready = '0;
    chk("t4_drained", 64'(fifo_level), 64'd0);
    clr_status = 1; tick(1); clr_status = 0;

    // simultaneous Update-IR and Update-DR
    send_uir(2'b10); tick(4);
    send_uir(2'b11); send_udr(1'b0, rnd_jdo()); tick(4);
    chk("t5_old_ir", 64'(cmd_if.cmd_ir), 64'd2);
    cmd_if.cmd_ready = 2'b01; tick(1); cmd_if.cmd_ready = '0;
    send_udr(1'b0, rnd_jdo()); tick(4);
    chk("t5_new_ir", 64'(cmd_if.cmd_ir), 64'd3);
    cmd_if.cmd_ready = 2'b01; tick(1); cmd_if.cmd_ready = '0;

    // reset with entries queued and a toggle in flight
    send_udr(1'b0, rnd_jdo()); tick(4);
    send_udr(1'b1, rnd_jdo()); tick(4);
    chk("t6_pre_level", 64'(fifo_level), 64'd2);
    send_udr(1'b0, rnd_jdo()); tick(1);
    do_reset();
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_valid", 64'(cmd_if.cmd_valid), 64'd0);
    tick(10);
    chk("t6_no_spurious", 64'(fifo_level), 64'd0);
    chk("t6_valid_late",  64'(cmd_if.cmd_valid), 64'd0);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 1 || r == 3) send_uir(IR_W'($urandom));
      if (r >= 2) send_udr(CH_W'($urandom), rnd_jdo());
      for (int c = 0; c < 4; c++) begin
        cmd_if.cmd_ready = NUM_CH'($urandom);
        clr_status = ($urandom_range(0, 15) == 0);
        tick(1);
      end
    end
    cmd_if.cmd_ready = '0;
    clr_status = 0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
